// File: rtl/fb_id_ex_pkg.sv
// Shared encodings for the Firebird ID/EX stage: opcodes, ALU op classes
// and the 10-bit control bundle produced by fb_cu.
package fb_id_ex_pkg;

   localparam int CTRL_W = 10;

   typedef enum logic [6:0] {
      OP_R      = 7'b0110011,
      OP_I      = 7'b0010011,
      OP_LOAD   = 7'b0000011,
      OP_STORE  = 7'b0100011,
      OP_BRANCH = 7'b1100011,
      OP_JAL    = 7'b1101111,
      OP_JALR   = 7'b1100111
   } opcode_e;

   typedef enum logic [1:0] {
      ALU_OP_ADD    = 2'b00,
      ALU_OP_BRANCH = 2'b01,
      ALU_OP_FUNCT  = 2'b10,
      ALU_OP_IMM    = 2'b11
   } alu_op_e;

   // Field order fixes the packed layout; an all-zero value is a safe bubble.
   typedef struct packed {
      logic [1:0] alu_op;
      logic       alu_src;
      logic       alu_res_src;
      logic       mem_read;
      logic       mem_write;
      logic       branch;
      logic       mem_to_reg;
      logic       reg_write;
      logic       jalr_en;
   } ctrl_t;

endpackage

// File: rtl/fb_hazard_detect.sv
// Load-use hazard detection between the ID instruction and a load in EX.
// Purely combinational so forwarding logic can reuse it.
module fb_hazard_detect (
   input  logic       id_valid,
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   input  logic       id_uses_rs1,
   input  logic       id_uses_rs2,
   input  logic       ex_valid,
   input  logic       ex_mem_read,
   input  logic [4:0] ex_rd,
   output logic       hazard
);

   logic rs1_match;
   logic rs2_match;

   assign rs1_match = id_uses_rs1 && (id_rs1 == ex_rd);
   assign rs2_match = id_uses_rs2 && (id_rs2 == ex_rd);

   // x0 is never really written, so a load to x0 cannot create a dependency.
   assign hazard = id_valid && ex_valid && ex_mem_read && (ex_rd != 5'd0)
                   && (rs1_match || rs2_match);

endmodule

// File: rtl/fb_id_ex.sv
// ID/EX pipeline register with load-use bubble insertion, flush handling,
// EX back-pressure and saturating stall/flush event counters.
module fb_id_ex
   import fb_id_ex_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_valid,
   input  logic [XLEN-1:0]  id_pc,
   input  logic [XLEN-1:0]  id_rs1_data,
   input  logic [XLEN-1:0]  id_rs2_data,
   input  logic [XLEN-1:0]  id_imm,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic [4:0]       id_rd,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  logic [2:0]       id_funct3,
   input  logic             id_funct7_5,
   input  logic [1:0]       id_alu_op,
   input  logic             id_alu_src,
   input  logic             id_alu_res_src,
   input  logic             id_mem_read,
   input  logic             id_mem_write,
   input  logic             id_branch,
   input  logic             id_mem_to_reg,
   input  logic             id_reg_write,
   input  logic             id_jalr_en,
   input  logic             flush,
   input  logic             ex_stall,
   output logic             ex_valid,
   output logic [XLEN-1:0]  ex_pc,
   output logic [XLEN-1:0]  ex_rs1_data,
   output logic [XLEN-1:0]  ex_rs2_data,
   output logic [XLEN-1:0]  ex_imm,
   output logic [4:0]       ex_rs1,
   output logic [4:0]       ex_rs2,
   output logic [4:0]       ex_rd,
   output logic [2:0]       ex_funct3,
   output logic             ex_funct7_5,
   output logic [1:0]       ex_alu_op,
   output logic             ex_alu_src,
   output logic             ex_alu_res_src,
   output logic             ex_mem_read,
   output logic             ex_mem_write,
   output logic             ex_branch,
   output logic             ex_mem_to_reg,
   output logic             ex_reg_write,
   output logic             ex_jalr_en,
   output logic             hold_id,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   ctrl_t             id_ctrl;
   ctrl_t             ex_ctrl;
   logic [CTRL_W-1:0] ctrl_q;
   logic              flush_pending;
   logic              flush_eff;
   logic              hazard;

   assign id_ctrl = '{alu_op:      id_alu_op,
                      alu_src:     id_alu_src,
                      alu_res_src: id_alu_res_src,
                      mem_read:    id_mem_read,
                      mem_write:   id_mem_write,
                      branch:      id_branch,
                      mem_to_reg:  id_mem_to_reg,
                      reg_write:   id_reg_write,
                      jalr_en:     id_jalr_en};

   assign ex_ctrl        = ctrl_t'(ctrl_q);
   assign ex_alu_op      = ex_ctrl.alu_op;
   assign ex_alu_src     = ex_ctrl.alu_src;
   assign ex_alu_res_src = ex_ctrl.alu_res_src;
   assign ex_mem_read    = ex_ctrl.mem_read;
   assign ex_mem_write   = ex_ctrl.mem_write;
   assign ex_branch      = ex_ctrl.branch;
   assign ex_mem_to_reg  = ex_ctrl.mem_to_reg;
   assign ex_reg_write   = ex_ctrl.reg_write;
   assign ex_jalr_en     = ex_ctrl.jalr_en;

   fb_hazard_detect u_hazard (
      .id_valid    (id_valid),
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .id_uses_rs1 (id_uses_rs1),
      .id_uses_rs2 (id_uses_rs2),
      .ex_valid    (ex_valid),
      .ex_mem_read (ex_mem_read),
      .ex_rd       (ex_rd),
      .hazard      (hazard)
   );

   assign flush_eff = flush || flush_pending;

   // A flushed ID instruction is discarded, so its hazard must not freeze IF/ID.
   assign hold_id = rst_n && (ex_stall || (hazard && !flush_eff));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid      <= 1'b0;
         ctrl_q        <= '0;
         ex_pc         <= '0;
         ex_rs1_data   <= '0;
         ex_rs2_data   <= '0;
         ex_imm        <= '0;
         ex_rs1        <= '0;
         ex_rs2        <= '0;
         ex_rd         <= '0;
         ex_funct3     <= '0;
         ex_funct7_5   <= 1'b0;
         flush_pending <= 1'b0;
         stall_cnt     <= '0;
         flush_cnt     <= '0;
      end else if (ex_stall) begin
         // EX is frozen; remember a flush so it is applied once EX frees up.
         if (flush) flush_pending <= 1'b1;
      end else if (flush_eff) begin
         ex_valid      <= 1'b0;
         ctrl_q        <= '0;
         flush_pending <= 1'b0;
         if (flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
      end else if (hazard) begin
         ex_valid <= 1'b0;
         ctrl_q   <= '0;
         if (stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      end else begin
         ex_valid    <= id_valid;
         ctrl_q      <= id_valid ? id_ctrl : '0;
         ex_pc       <= id_pc;
         ex_rs1_data <= id_rs1_data;
         ex_rs2_data <= id_rs2_data;
         ex_imm      <= id_imm;
         ex_rs1      <= id_rs1;
         ex_rs2      <= id_rs2;
         ex_rd       <= id_rd;
         ex_funct3   <= id_funct3;
         ex_funct7_5 <= id_funct7_5;
      end
   end

endmodule

// File: tb/tb_fb_id_ex.sv
// Directed bench for fb_id_ex: a vector table for single-edge behaviour plus
// hand sequences for flush-under-stall, counter saturation and async reset.
module tb_fb_id_ex;

   localparam logic [9:0] C_R    = 10'b10_0_0_0_0_0_0_1_0;
   localparam logic [9:0] C_LW   = 10'b00_1_0_1_0_0_1_1_0;
   localparam logic [9:0] C_BR   = 10'b01_0_0_0_0_1_0_0_0;
   localparam logic [9:0] C_JALR = 10'b00_1_1_0_0_0_0_1_1;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        id_valid;
   logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic        id_uses_rs1, id_uses_rs2;
   logic [2:0]  id_funct3;
   logic        id_funct7_5;
   logic [1:0]  id_alu_op;
   logic        id_alu_src, id_alu_res_src, id_mem_read, id_mem_write;
   logic        id_branch, id_mem_to_reg, id_reg_write, id_jalr_en;
   logic        flush, ex_stall;
   logic        ex_valid;
   logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
   logic [4:0]  ex_rs1, ex_rs2, ex_rd;
   logic [2:0]  ex_funct3;
   logic        ex_funct7_5;
   logic [1:0]  ex_alu_op;
   logic        ex_alu_src, ex_alu_res_src, ex_mem_read, ex_mem_write;
   logic        ex_branch, ex_mem_to_reg, ex_reg_write, ex_jalr_en;
   logic        hold_id;
   logic [1:0]  stall_cnt, flush_cnt;
   logic [9:0]  ex_ctrl;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fb_id_ex #(.XLEN(32), .CNT_W(2)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
      .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .id_funct3(id_funct3), .id_funct7_5(id_funct7_5), .id_alu_op(id_alu_op),
      .id_alu_src(id_alu_src), .id_alu_res_src(id_alu_res_src),
      .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
      .id_branch(id_branch), .id_mem_to_reg(id_mem_to_reg),
      .id_reg_write(id_reg_write), .id_jalr_en(id_jalr_en),
      .flush(flush), .ex_stall(ex_stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
      .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct3(ex_funct3),
      .ex_funct7_5(ex_funct7_5), .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src),
      .ex_alu_res_src(ex_alu_res_src), .ex_mem_read(ex_mem_read),
      .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
      .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write),
      .ex_jalr_en(ex_jalr_en), .hold_id(hold_id), .stall_cnt(stall_cnt),
      .flush_cnt(flush_cnt)
   );

   assign ex_ctrl = {ex_alu_op, ex_alu_src, ex_alu_res_src, ex_mem_read, ex_mem_write,
                     ex_branch, ex_mem_to_reg, ex_reg_write, ex_jalr_en};

   typedef struct {
      logic        valid;
      logic [31:0] pc;
      logic [4:0]  rs1, rs2, rd;
      logic        u1, u2;
      logic [9:0]  ctrl;
      logic        fl, st;
      logic        exp_hold;
      int          exp_src;     // vector whose fields EX should hold after the edge
      logic        exp_valid;
      logic        exp_live;    // 1: EX ctrl equals source ctrl, 0: all zero
      int          exp_stall;
      int          exp_flush;
   } vec_t;

   vec_t vecs[12];

   function automatic vec_t mk(logic v, logic [31:0] pc, logic [4:0] rs1, logic [4:0] rs2,
                               logic [4:0] rd, logic u1, logic u2, logic [9:0] c,
                               logic fl, logic st, logic eh, int src, logic ev,
                               logic el, int es, int ef);
      vec_t r;
      r.valid = v; r.pc = pc; r.rs1 = rs1; r.rs2 = rs2; r.rd = rd; r.u1 = u1; r.u2 = u2;
      r.ctrl = c; r.fl = fl; r.st = st; r.exp_hold = eh; r.exp_src = src;
      r.exp_valid = ev; r.exp_live = el; r.exp_stall = es; r.exp_flush = ef;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drv(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [4:0] rd, input logic u1,
                      input logic u2, input logic [9:0] c, input logic fl, input logic st);
      id_valid = v; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
      id_uses_rs1 = u1; id_uses_rs2 = u2;
      id_rs1_data = pc ^ 32'hA5A5_0000;
      id_rs2_data = pc ^ 32'h0000_5A5A;
      id_imm      = ~pc;
      id_funct3   = pc[4:2];
      id_funct7_5 = pc[5];
      {id_alu_op, id_alu_src, id_alu_res_src, id_mem_read, id_mem_write,
       id_branch, id_mem_to_reg, id_reg_write, id_jalr_en} = c;
      flush = fl; ex_stall = st;
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      vecs[0]  = mk(1, 32'h40, 1,  2,  5,  1, 1, C_R,    0, 0, 0, 0,  1, 1, 0, 0);
      vecs[1]  = mk(1, 32'h44, 5,  0,  7,  1, 0, C_LW,   0, 0, 0, 1,  1, 1, 0, 0);
      vecs[2]  = mk(1, 32'h48, 3,  7,  8,  1, 1, C_R,    0, 0, 1, 1,  0, 0, 1, 0);
      vecs[3]  = mk(1, 32'h48, 3,  7,  8,  1, 1, C_R,    0, 0, 0, 3,  1, 1, 1, 0);
      vecs[4]  = mk(1, 32'h4C, 1,  0,  0,  1, 0, C_LW,   0, 0, 0, 4,  1, 1, 1, 0);
      vecs[5]  = mk(1, 32'h50, 0,  0,  9,  1, 1, C_BR,   0, 0, 0, 5,  1, 1, 1, 0);
      vecs[6]  = mk(1, 32'h54, 2,  0,  10, 1, 0, C_LW,   0, 0, 0, 6,  1, 1, 1, 0);
      vecs[7]  = mk(1, 32'h58, 10, 11, 12, 0, 1, C_JALR, 0, 0, 0, 7,  1, 1, 1, 0);
      vecs[8]  = mk(1, 32'h5C, 1,  0,  13, 1, 0, C_LW,   0, 0, 0, 8,  1, 1, 1, 0);
      vecs[9]  = mk(1, 32'h60, 13, 4,  14, 1, 1, C_R,    1, 0, 0, 8,  0, 0, 1, 1);
      vecs[10] = mk(0, 32'h64, 4,  5,  14, 1, 1, 10'h3FF, 0, 0, 0, 10, 0, 0, 1, 1);
      vecs[11] = mk(1, 32'h68, 1,  0,  15, 1, 0, C_LW,   0, 1, 1, 10, 0, 0, 1, 1);

      rst_n = 1'b0;
      drv(0, 0, 0, 0, 0, 0, 0, 10'h0, 0, 1);
      #2;
      chk("rst_valid", 32'(ex_valid), 0);
      chk("rst_pc", ex_pc, 0);
      chk("rst_ctrl", 32'(ex_ctrl), 0);
      chk("rst_cnts", {stall_cnt, flush_cnt}, 0);
      chk("rst_hold", 32'(hold_id), 0);
      @(negedge clk);
      rst_n = 1'b1;
      ex_stall = 1'b0;

      for (int k = 0; k < 12; k++) begin
         int s;
         drv(vecs[k].valid, vecs[k].pc, vecs[k].rs1, vecs[k].rs2, vecs[k].rd,
             vecs[k].u1, vecs[k].u2, vecs[k].ctrl, vecs[k].fl, vecs[k].st);
         #1;
         chk($sformatf("v%0d_hold", k), 32'(hold_id), 32'(vecs[k].exp_hold));
         step();
         s = vecs[k].exp_src;
         chk($sformatf("v%0d_valid", k), 32'(ex_valid), 32'(vecs[k].exp_valid));
         chk($sformatf("v%0d_ctrl", k), 32'(ex_ctrl),
             vecs[k].exp_live ? 32'(vecs[s].ctrl) : 32'h0);
         chk($sformatf("v%0d_pc", k), ex_pc, vecs[s].pc);
         chk($sformatf("v%0d_idx", k), {17'h0, ex_rs1, ex_rs2, ex_rd},
             {17'h0, vecs[s].rs1, vecs[s].rs2, vecs[s].rd});
         chk($sformatf("v%0d_d1", k), ex_rs1_data, vecs[s].pc ^ 32'hA5A5_0000);
         chk($sformatf("v%0d_d2", k), ex_rs2_data, vecs[s].pc ^ 32'h0000_5A5A);
         chk($sformatf("v%0d_imm", k), ex_imm, ~vecs[s].pc);
         chk($sformatf("v%0d_fn", k), {28'h0, ex_funct7_5, ex_funct3},
             {28'h0, vecs[s].pc[5], vecs[s].pc[4:2]});
         chk($sformatf("v%0d_scnt", k), 32'(stall_cnt), vecs[k].exp_stall);
         chk($sformatf("v%0d_fcnt", k), 32'(flush_cnt), vecs[k].exp_flush);
      end

      // flush arriving while EX is stalled is deferred to the first free edge
      drv(1, 32'h80, 1, 2, 3, 1, 1, C_R, 0, 0);
      step();
      chk("fs_load_valid", 32'(ex_valid), 1);
      drv(1, 32'h84, 1, 2, 4, 1, 1, C_R, 1, 1);
      #1;
      chk("fs_hold", 32'(hold_id), 1);
      step();
      chk("fs_a_pc", ex_pc, 32'h80);
      chk("fs_a_valid", 32'(ex_valid), 1);
      chk("fs_a_fcnt", 32'(flush_cnt), 1);
      for (int i = 0; i < 2; i++) begin
         drv(1, 32'h84, 1, 2, 4, 1, 1, C_R, 0, 1);
         step();
         chk("fs_b_pc", ex_pc, 32'h80);
         chk("fs_b_valid", 32'(ex_valid), 1);
      end
      drv(1, 32'h88, 1, 2, 6, 1, 1, C_R, 0, 0);
      #1;
      chk("fs_d_hold", 32'(hold_id), 0);
      step();
      chk("fs_d_valid", 32'(ex_valid), 0);
      chk("fs_d_rw", 32'(ex_reg_write), 0);
      chk("fs_d_pc", ex_pc, 32'h80);
      chk("fs_d_fcnt", 32'(flush_cnt), 2);
      step();
      chk("fs_e_valid", 32'(ex_valid), 1);
      chk("fs_e_pc", ex_pc, 32'h88);
      chk("fs_e_fcnt", 32'(flush_cnt), 2);

      // five load-use pairs push stall_cnt from 1 into saturation at 3
      for (int i = 0; i < 5; i++) begin
         logic [31:0] base;
         base = 32'h100 + 32'(i * 8);
         drv(1, base, 1, 0, 7, 1, 0, C_LW, 0, 0);
         step();
         drv(1, base + 4, 2, 7, 8, 0, 1, C_R, 0, 0);
         #1;
         chk("sat_hold", 32'(hold_id), 1);
         step();
         chk("sat_bubble", 32'(ex_valid), 0);
         chk("sat_scnt", 32'(stall_cnt), (i + 2 > 3) ? 3 : i + 2);
         step();
         chk("sat_add_pc", ex_pc, base + 4);
      end
      drv(1, 32'h180, 1, 2, 9, 1, 1, C_R, 1, 0);
      step();
      chk("fsat_1", 32'(flush_cnt), 3);
      step();
      chk("fsat_2", 32'(flush_cnt), 3);
      chk("fsat_valid", 32'(ex_valid), 0);

      // asynchronous reset between edges while EX holds a live instruction
      drv(1, 32'h200, 1, 2, 5, 1, 1, C_R, 0, 0);
      step();
      chk("ar_pre_valid", 32'(ex_valid), 1);
      ex_stall = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk("ar_valid", 32'(ex_valid), 0);
      chk("ar_rw", 32'(ex_reg_write), 0);
      chk("ar_cnts", {stall_cnt, flush_cnt}, 0);
      chk("ar_hold", 32'(hold_id), 0);
      @(negedge clk);
      rst_n = 1'b1;
      drv(1, 32'h204, 1, 2, 5, 1, 1, C_R, 0, 0);
      step();
      chk("ar_post_pc", ex_pc, 32'h204);
      chk("ar_post_valid", 32'(ex_valid), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fb_id_ex.md
Name: fb_id_ex

Overview:
- ID/EX pipeline stage register for the Firebird 5-stage RV32I pipeline.
- Captures decode-stage operands together with the control bundle produced by fb_cu, and presents them to EX one cycle later.
- Owns load-use hazard detection. On a hazard it inserts a bubble into EX and tells IF/ID and PC to hold.
- Applies control-hazard flushes, honours downstream back-pressure, and keeps saturating stall/flush event counters.

Parameters:
- XLEN, 32, datapath width (rs data, imm, pc).
- CNT_W, 16, width of the stall and flush event counters.

Ports:
- clk in 1 system clock.
- rst_n in 1 asynchronous active-low reset.
- id_valid in 1 ID holds a real instruction.
- id_pc in XLEN pc of the ID instruction.
- id_rs1_data in XLEN rs1 operand.
- id_rs2_data in XLEN rs2 operand.
- id_imm in XLEN immediate.
- id_rs1 in 5 rs1 index.
- id_rs2 in 5 rs2 index.
- id_rd in 5 rd index.
- id_uses_rs1 in 1 instruction reads rs1.
- id_uses_rs2 in 1 instruction reads rs2.
- id_funct3 in 3 funct3 field.
- id_funct7_5 in 1 instr[30].
- id_alu_op in 2 fb_cu control output.
- id_alu_src, id_alu_res_src, id_mem_read, id_mem_write, id_branch, id_mem_to_reg, id_reg_write, id_jalr_en in 1 each, fb_cu control outputs.
- flush in 1 control-hazard unit: the ID instruction is wrong-path.
- ex_stall in 1 EX/MEM cannot accept; hold EX.
- ex_valid out 1 EX slot holds a real instruction.
- ex_pc, ex_rs1_data, ex_rs2_data, ex_imm out XLEN registered copies.
- ex_rs1, ex_rs2, ex_rd out 5 registered indices.
- ex_funct3 out 3 registered.
- ex_funct7_5 out 1 registered.
- ex_alu_op out 2 registered.
- ex_alu_src ... ex_jalr_en out 1 each, registered control bundle.
- hold_id out 1 IF/ID and PC must not advance.
- stall_cnt out CNT_W count of load-use bubbles inserted.
- flush_cnt out CNT_W count of flushes applied.

Behaviour:
- Reset (rst_n low, asynchronous):
  - ex_valid, all ex_* outputs, flush_pending, stall_cnt and flush_cnt clear to 0.
  - hold_id is 0 while in reset.
- Latency: one cycle from ID inputs to ex_* outputs.
- Definitions:
  - flush_eff = flush | flush_pending.
  - hazard = id_valid & ex_valid & ex_mem_read & (ex_rd != 0) & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd)).
- hold_id (combinational) = ex_stall | (hazard & ~flush_eff).
- Per-edge priority, highest first:
  - (1) ex_stall = 1: every ex_* register holds. If flush = 1, set flush_pending. Counters unchanged.
  - (2) flush_eff = 1: load a bubble (ex_valid = 0, all control bits 0, data fields don't-care and held). Clear flush_pending. flush_cnt += 1.
  - (3) hazard = 1: load a bubble. stall_cnt += 1.
  - (4) otherwise: load all id_* fields. ex_valid = id_valid.
- A bubble carries reg_write = mem_write = mem_read = branch = jalr_en = 0, so it can cause no architectural side effect.
- id_valid = 0 with no flush/hazard: the register loads with ex_valid = 0 and control bits forced to 0.
- A hazard whose ID instruction is flushed the same cycle counts as a flush only, not as a stall.
- Back-to-back: after a bubble, ex_valid = 0, so hazard deasserts and the held instruction loads on the next edge. Maximum one bubble per load.
- Counters saturate at 2^CNT_W-1 and never wrap.
- rs index 0 never triggers a hazard.

Decomposition:
- fb_defines.v gains:
  - opcode constants (R/I/LOAD/STORE/BRANCH/JAL/JALR).
  - ALU_OP encodings 2'b00/01/10/11.
  - a CTRL_W width macro for the 10-bit control bundle.
- Sub-module fb_hazard_detect: purely combinational, inputs id/ex indices, uses and ex_mem_read/ex_valid, output hazard. Reused by future forwarding logic.
- Counters and the flush_pending flop live in fb_id_ex.

Test Plan:
- Reset mid-operation: assert rst_n = 0 between edges while ex_valid = 1 -> ex_valid, ex_reg_write, stall_cnt and flush_cnt read 0 immediately, with no clock.
- Normal flow: id_valid = 1, id_pc = 0x40, id_reg_write = 1, id_rd = 5 -> next edge ex_pc = 0x40, ex_rd = 5, ex_valid = 1, hold_id = 0.
- Load-use bubble:
  - stimulus: ex holds lw, ex_rd = 7; ID holds add, id_rs2 = 7, id_uses_rs2 = 1.
  - response: hold_id = 1; next edge ex_valid = 0, ex_reg_write = 0, stall_cnt = 1; following edge add loads, hold_id = 0.
  - with ex_rd = 0 instead: no stall.
- Flush during stall:
  - stimulus: ex_stall = 1 and flush = 1 for one cycle, then ex_stall = 0 two cycles later.
  - response: EX holds throughout the stall; first free edge loads a bubble, flush_cnt = 1, flush_pending = 0.
- Simultaneous flush and hazard: both true at one edge -> bubble, flush_cnt = 1, stall_cnt = 0, hold_id = 0.
- Saturation: CNT_W = 2, drive 5 load-use hazards -> stall_cnt sticks at 3.
